// File: rtl/axi_llc_way_bank.sv
// axi_llc_way_bank: one LLC data way as seen from the way crossbar.
// Tagged write/read requests hit a byte-maskable line memory; read results
// travel a fixed-latency tagged pipeline into an in-order response FIFO.
// A credit counter reserves a FIFO slot for every accepted read, so the
// pipeline never has to stall on output backpressure.

// Protocol/occupancy checks for the way bank (simulation only).
module axi_llc_way_bank_chk #(
  parameter int unsigned OutDepth = 2,
  parameter int unsigned CW       = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          i_push,
  input logic          i_pop,
  input logic          i_rd_acc,
  input logic [CW-1:0] i_fifo_cnt,
  input logic [CW-1:0] i_cnt
);

  // A pipeline result must always find room in the response FIFO.
  a_push_not_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(i_push && (i_fifo_cnt == CW'(OutDepth))));

  // A response can only leave if a credit was taken for it.
  a_cnt_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(i_pop && !i_rd_acc && (i_cnt == '0)));

  // Outstanding reads never exceed the number of response slots.
  a_cnt_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    (i_cnt <= CW'(OutDepth)));

endmodule

module axi_llc_way_bank #(
  parameter int unsigned NumLines  = 256,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Latency   = 1,
  parameter int unsigned OutDepth  = 2,
  parameter int unsigned UnitWidth = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        inp_valid_i,
  output logic                        inp_ready_o,
  input  logic                        inp_we_i,
  input  logic [$clog2(NumLines)-1:0] inp_line_i,
  input  logic [DataWidth-1:0]        inp_data_i,
  input  logic [DataWidth/8-1:0]      inp_strb_i,
  input  logic [UnitWidth-1:0]        inp_unit_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DataWidth-1:0]        out_data_o,
  output logic [UnitWidth-1:0]        out_unit_o
);

  localparam int unsigned SW = DataWidth / 8;
  localparam int unsigned CW = $clog2(OutDepth + 1);
  localparam int unsigned PW = (OutDepth > 1) ? $clog2(OutDepth) : 1;

  // Per-stage occupancy of the read-latency pipeline.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } stage_e;

  // Wrap-around increment for FIFO pointers (depth need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(OutDepth - 1)) begin
      n = '0;
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshakes and credits
  // ---------------------------------------------------------------------------
  logic [CW-1:0]        r_cnt;
  logic                 w_rd_acc;
  logic                 w_wr_acc;
  logic                 w_pop;
  logic                 w_push;
  logic [DataWidth-1:0] w_push_data;
  logic [UnitWidth-1:0] w_push_unit;
  logic [DataWidth-1:0] w_rd_data;

  // Writes are always accepted; reads need a free response credit.
  assign inp_ready_o = inp_we_i | (r_cnt < CW'(OutDepth));
  assign w_rd_acc    = inp_valid_i & inp_ready_o & ~inp_we_i;
  assign w_wr_acc    = inp_valid_i & inp_we_i;

  // Credit counter: one credit per outstanding read (pipeline + FIFO).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      case ({w_rd_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Line memory (contents survive reset)
  // ---------------------------------------------------------------------------
  logic [DataWidth-1:0] r_mem [NumLines];

  assign w_rd_data = r_mem[inp_line_i];

  // Byte-masked line write; suppressed while reset is asserted.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc && !rst_i) begin
      for (int b = 0; b < SW; b++) begin
        if (inp_strb_i[b]) begin
          r_mem[inp_line_i][b*8 +: 8] <= inp_data_i[b*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-latency pipeline: the accept cycle is the first stage, so Latency-1
  // register stages follow before the result is pushed into the FIFO.
  // ---------------------------------------------------------------------------
  if (Latency == 1) begin : g_lat1
    assign w_push      = w_rd_acc;
    assign w_push_data = w_rd_data;
    assign w_push_unit = inp_unit_i;
  end else begin : g_pipe
    localparam int unsigned SD = Latency - 1;

    stage_e               r_st [SD];
    logic [DataWidth-1:0] r_pd [SD];
    logic [UnitWidth-1:0] r_pu [SD];

    // Stage state machine: every stage shifts unconditionally each cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < SD; i++) begin
          r_st[i] <= ST_EMPTY;
          r_pd[i] <= '0;
          r_pu[i] <= '0;
        end
      end else begin
        case (w_rd_acc)
          1'b1:    r_st[0] <= ST_HOLD;
          default: r_st[0] <= ST_EMPTY;
        endcase
        r_pd[0] <= w_rd_data;
        r_pu[0] <= inp_unit_i;
        for (int i = 1; i < SD; i++) begin
          r_st[i] <= r_st[i-1];
          r_pd[i] <= r_pd[i-1];
          r_pu[i] <= r_pu[i-1];
        end
      end
    end

    assign w_push      = (r_st[SD-1] == ST_HOLD);
    assign w_push_data = r_pd[SD-1];
    assign w_push_unit = r_pu[SD-1];
  end

  // ---------------------------------------------------------------------------
  // Response FIFO; head entry drives the outputs directly from registers.
  // ---------------------------------------------------------------------------
  logic [DataWidth-1:0] r_fd [OutDepth];
  logic [UnitWidth-1:0] r_fu [OutDepth];
  logic [PW-1:0]        r_rptr;
  logic [PW-1:0]        r_wptr;
  logic [CW-1:0]        r_fcnt;

  assign out_valid_o = (r_fcnt != '0);
  assign out_data_o  = r_fd[r_rptr];
  assign out_unit_o  = r_fu[r_rptr];
  assign w_pop       = out_valid_o & out_ready_i;

  // FIFO storage, pointers and occupancy; entries cleared so outputs reset to 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < OutDepth; i++) begin
        r_fd[i] <= '0;
        r_fu[i] <= '0;
      end
      r_rptr <= '0;
      r_wptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) begin
        r_fd[r_wptr] <= w_push_data;
        r_fu[r_wptr] <= w_push_unit;
        r_wptr       <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CW'(1);
        2'b01:   r_fcnt <= r_fcnt - CW'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  axi_llc_way_bank_chk #(
    .OutDepth (OutDepth),
    .CW       (CW)
  ) u_chk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_rd_acc   (w_rd_acc),
    .i_fifo_cnt (r_fcnt),
    .i_cnt      (r_cnt)
  );

endmodule

// File: tb/tb_axi_llc_way_bank.sv
// Directed self-checking bench: instance A (Latency=1, OutDepth=2) and
// instance B (Latency=3, OutDepth=4) share clock and reset.
module tb_axi_llc_way_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] D5  = 64'h1122334455667788;
  localparam logic [63:0] D7  = 64'h00000000FFFFFFFF;
  localparam logic [63:0] D9  = 64'hCAFEBABEDEADBEEF;
  localparam logic [63:0] D12 = 64'h0F1E2D3C4B5A6978;

  // Instance A signals
  logic        a_valid = 1'b0, a_ready, a_we = 1'b0;
  logic [7:0]  a_line = 8'd0;
  logic [63:0] a_data = 64'd0;
  logic [7:0]  a_strb = 8'd0;
  logic [1:0]  a_unit = 2'd0;
  logic        a_ovalid, a_oready = 1'b0;
  logic [63:0] a_odata;
  logic [1:0]  a_ounit;

  // Instance B signals
  logic        b_valid = 1'b0, b_ready, b_we = 1'b0;
  logic [7:0]  b_line = 8'd0;
  logic [63:0] b_data = 64'd0;
  logic [7:0]  b_strb = 8'd0;
  logic [1:0]  b_unit = 2'd0;
  logic        b_ovalid, b_oready = 1'b0;
  logic [63:0] b_odata;
  logic [1:0]  b_ounit;

  axi_llc_way_bank #(.NumLines(256), .DataWidth(64), .Latency(1), .OutDepth(2), .UnitWidth(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .inp_valid_i(a_valid), .inp_ready_o(a_ready), .inp_we_i(a_we),
    .inp_line_i(a_line), .inp_data_i(a_data), .inp_strb_i(a_strb), .inp_unit_i(a_unit),
    .out_valid_o(a_ovalid), .out_ready_i(a_oready), .out_data_o(a_odata), .out_unit_o(a_ounit)
  );

  axi_llc_way_bank #(.NumLines(256), .DataWidth(64), .Latency(3), .OutDepth(4), .UnitWidth(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .inp_valid_i(b_valid), .inp_ready_o(b_ready), .inp_we_i(b_we),
    .inp_line_i(b_line), .inp_data_i(b_data), .inp_strb_i(b_strb), .inp_unit_i(b_unit),
    .out_valid_o(b_ovalid), .out_ready_i(b_oready), .out_data_o(b_odata), .out_unit_o(b_ounit)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic we, input logic [7:0] line,
                         input logic [63:0] data, input logic [7:0] strb, input logic [1:0] unit);
    a_valid = v; a_we = we; a_line = line; a_data = data; a_strb = strb; a_unit = unit;
  endtask

  task automatic b_drive(input logic v, input logic we, input logic [7:0] line,
                         input logic [63:0] data, input logic [7:0] strb, input logic [1:0] unit);
    b_valid = v; b_we = we; b_line = line; b_data = data; b_strb = strb; b_unit = unit;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
    checks++; if (a_ovalid !== 1'b0) begin failures++; $display("FAIL reset_ovalid got=%b exp=0", a_ovalid); end
    checks++; if (a_odata !== 64'd0) begin failures++; $display("FAIL reset_odata got=%h exp=0", a_odata); end
    checks++; if (a_ounit !== 2'd0) begin failures++; $display("FAIL reset_ounit got=%0d exp=0", a_ounit); end
    checks++; if (b_ovalid !== 1'b0) begin failures++; $display("FAIL reset_b_ovalid got=%b exp=0", b_ovalid); end
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    step();
    a_oready = 1'b1;
    a_drive(1'b1, 1'b1, 8'd5, D5, 8'hFF, 2'd0);
    step();
    a_drive(1'b1, 1'b0, 8'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 2'd3);
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL wr_rd_ready got=%b exp=1", a_ready); end
    checks++; if (a_ovalid !== 1'b0) begin failures++; $display("FAIL wr_rd_early got=%b exp=0", a_ovalid); end
    step();
    a_drive(1'b0, 1'b0, 8'd0, 64'd0, 8'h00, 2'd0);
    checks++; if (a_ovalid !== 1'b1) begin failures++; $display("FAIL wr_rd_valid got=%b exp=1", a_ovalid); end
    checks++; if (a_odata !== D5) begin failures++; $display("FAIL wr_rd_data got=%h exp=%h", a_odata, D5); end
    checks++; if (a_ounit !== 2'd3) begin failures++; $display("FAIL wr_rd_unit got=%0d exp=3", a_ounit); end
    step();
    checks++; if (a_ovalid !== 1'b0) begin failures++; $display("FAIL wr_rd_after got=%b exp=0", a_ovalid); end
  endtask

  task automatic test_strobe();
    a_drive(1'b1, 1'b1, 8'd7, 64'd0, 8'hFF, 2'd0);
    step();
    a_drive(1'b1, 1'b1, 8'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 2'd0);
    step();
    a_drive(1'b1, 1'b0, 8'd7, 64'd0, 8'h00, 2'd2);
    step();
    a_drive(1'b0, 1'b0, 8'd0, 64'd0, 8'h00, 2'd0);
    checks++; if (a_ovalid !== 1'b1) begin failures++; $display("FAIL strb_valid got=%b exp=1", a_ovalid); end
    checks++; if (a_odata !== D7) begin failures++; $display("FAIL strb_data got=%h exp=%h", a_odata, D7); end
    checks++; if (a_ounit !== 2'd2) begin failures++; $display("FAIL strb_unit got=%0d exp=2", a_ounit); end
    step();
  endtask

  task automatic test_backpressure();
    a_oready = 1'b0;
    step();
    a_drive(1'b1, 1'b0, 8'd5, 64'd0, 8'h00, 2'd1);
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL bp_ready0 got=%b exp=1", a_ready); end
    step();
    a_drive(1'b1, 1'b0, 8'd7, 64'd0, 8'h00, 2'd2);
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", a_ready); end
    step();
    a_drive(1'b1, 1'b0, 8'd5, 64'd0, 8'hFF, 2'd0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL bp_blocked c=%0d got=%b exp=0", c, a_ready); end
      checks++; if (a_ovalid !== 1'b1 || a_odata !== D5 || a_ounit !== 2'd1) begin
        failures++; $display("FAIL bp_hold c=%0d got=%b/%h/%0d exp=1/%h/1", c, a_ovalid, a_odata, a_ounit, D5);
      end
      step();
    end
    a_oready = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_indep got=%b exp=0", a_ready); end
    checks++; if (a_ovalid !== 1'b1 || a_ounit !== 2'd1) begin failures++; $display("FAIL bp_r0 got=%b/%0d exp=1/1", a_ovalid, a_ounit); end
    step();
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL bp_third_acc got=%b exp=1", a_ready); end
    checks++; if (a_ovalid !== 1'b1 || a_odata !== D7 || a_ounit !== 2'd2) begin
      failures++; $display("FAIL bp_r1 got=%b/%h/%0d exp=1/%h/2", a_ovalid, a_odata, a_ounit, D7);
    end
    step();
    a_drive(1'b0, 1'b0, 8'd0, 64'd0, 8'h00, 2'd0);
    checks++; if (a_ovalid !== 1'b1 || a_odata !== D5 || a_ounit !== 2'd0) begin
      failures++; $display("FAIL bp_r2 got=%b/%h/%0d exp=1/%h/0", a_ovalid, a_odata, a_ounit, D5);
    end
    step();
    checks++; if (a_ovalid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", a_ovalid); end
  endtask

  task automatic test_full_write();
    a_oready = 1'b0;
    a_drive(1'b1, 1'b0, 8'd5, 64'd0, 8'h00, 2'd1);
    step();
    a_drive(1'b1, 1'b0, 8'd7, 64'd0, 8'h00, 2'd2);
    step();
    a_drive(1'b1, 1'b0, 8'd9, 64'd0, 8'h00, 2'd3);
    #1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL full_rd_blocked got=%b exp=0", a_ready); end
    a_drive(1'b1, 1'b1, 8'd9, D9, 8'hFF, 2'd0);
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL full_wr_ready got=%b exp=1", a_ready); end
    step();
    a_drive(1'b0, 1'b0, 8'd0, 64'd0, 8'h00, 2'd0);
    a_oready = 1'b1;
    checks++; if (a_ovalid !== 1'b1 || a_odata !== D5 || a_ounit !== 2'd1) begin
      failures++; $display("FAIL full_r0 got=%b/%h/%0d exp=1/%h/1", a_ovalid, a_odata, a_ounit, D5);
    end
    step();
    checks++; if (a_ovalid !== 1'b1 || a_odata !== D7 || a_ounit !== 2'd2) begin
      failures++; $display("FAIL full_r1 got=%b/%h/%0d exp=1/%h/2", a_ovalid, a_odata, a_ounit, D7);
    end
    step();
    a_drive(1'b1, 1'b0, 8'd9, 64'd0, 8'h00, 2'd3);
    checks++; if (a_ovalid !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", a_ovalid); end
    step();
    a_drive(1'b0, 1'b0, 8'd0, 64'd0, 8'h00, 2'd0);
    checks++; if (a_ovalid !== 1'b1 || a_odata !== D9 || a_ounit !== 2'd3) begin
      failures++; $display("FAIL full_r9 got=%b/%h/%0d exp=1/%h/3", a_ovalid, a_odata, a_ounit, D9);
    end
    step();
  endtask

  task automatic test_reset_mid();
    a_oready = 1'b0;
    a_drive(1'b1, 1'b1, 8'd12, D12, 8'hFF, 2'd0);
    step();
    a_drive(1'b1, 1'b0, 8'd12, 64'd0, 8'h00, 2'd1);
    step();
    a_drive(1'b1, 1'b0, 8'd12, 64'd0, 8'h00, 2'd2);
    step();
    a_drive(1'b1, 1'b1, 8'd12, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'd0);
    checks++; if (a_ovalid !== 1'b1) begin failures++; $display("FAIL rstm_pending got=%b exp=1", a_ovalid); end
    rst = 1'b1;
    #1;
    checks++; if (a_ovalid !== 1'b0) begin failures++; $display("FAIL rstm_async got=%b exp=0", a_ovalid); end
    step();
    rst = 1'b0;
    a_drive(1'b0, 1'b0, 8'd0, 64'd0, 8'h00, 2'd0);
    a_oready = 1'b1;
    #1;
    checks++; if (a_odata !== 64'd0 || a_ounit !== 2'd0) begin
      failures++; $display("FAIL rstm_outs got=%h/%0d exp=0/0", a_odata, a_ounit);
    end
    for (int c = 0; c < 3; c++) begin
      checks++; if (a_ovalid !== 1'b0) begin failures++; $display("FAIL rstm_stale c=%0d got=%b exp=0", c, a_ovalid); end
      step();
    end
    a_oready = 1'b0;
    a_drive(1'b1, 1'b0, 8'd12, 64'd0, 8'h00, 2'd3);
    step();
    a_drive(1'b1, 1'b0, 8'd12, 64'd0, 8'h00, 2'd2);
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rstm_cnt_cleared got=%b exp=1", a_ready); end
    a_drive(1'b0, 1'b0, 8'd0, 64'd0, 8'h00, 2'd0);
    a_oready = 1'b1;
    checks++; if (a_ovalid !== 1'b1 || a_odata !== D12 || a_ounit !== 2'd3) begin
      failures++; $display("FAIL rstm_mem got=%b/%h/%0d exp=1/%h/3", a_ovalid, a_odata, a_ounit, D12);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_d;
    logic        exp_v;
    b_oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_drive(1'b1, 1'b1, 8'(i), 64'hB0B0_0000_0000_0000 | 64'(i), 8'hFF, 2'd0);
      step();
    end
    for (int k = 0; k < 8; k++) begin
      if (k < 4) b_drive(1'b1, 1'b0, 8'(k), 64'd0, 8'h00, 2'(k));
      else       b_drive(1'b0, 1'b0, 8'd0, 64'd0, 8'h00, 2'd0);
      #1;
      exp_v = (k >= 3) && (k <= 6);
      checks++; if (b_ovalid !== exp_v) begin failures++; $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, b_ovalid, exp_v); end
      if (exp_v) begin
        exp_d = 64'hB0B0_0000_0000_0000 | 64'(k - 3);
        checks++; if (b_odata !== exp_d || b_ounit !== 2'(k - 3)) begin
          failures++; $display("FAIL b2b_resp k=%0d got=%h/%0d exp=%h/%0d", k, b_odata, b_ounit, exp_d, k - 3);
        end
      end
      if (k < 4) begin
        checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, b_ready); end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_backpressure();
    test_full_write();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
